serial_subtractor: RTL
======================

Name: serial_subtractor

Overview:
- Bit-serial N-bit subtractor; computes diff = a - b, LSB first, one bit per clock.
- Inverse-direction companion to the combinational half/full adders.
- Built around a single full-subtractor cell and a borrow flip-flop.
- Used where area matters more than latency; start/busy/done handshake to a controlling FSM.

Parameters:
- WIDTH, 8, operand and result width in bits (>= 2).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- a  input  WIDTH  minuend; captured on the accepting edge.
- b  input  WIDTH  subtrahend; captured on the accepting edge.
- diff  output  WIDTH  result register; held until the next result is written.
- borrow_out  output  1  final borrow; 1 when a < b unsigned.
- busy  output  1  high in SHIFT state.
- done  output  1  one-cycle pulse; diff and borrow_out are valid from that cycle onward.

Behaviour:
- Reset (sampled at a clock edge with reset=1):
  - state=IDLE; diff=0, borrow_out=0, busy=0, done=0.
  - Internal shift registers, borrow flop and bit counter cleared.
  - reset overrides all other inputs, including in mid-operation; a partial result is discarded and diff keeps the reset value 0.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - Edge with start=1: a_sh<=a, b_sh<=b, borrow<=0, cnt<=0; go to SHIFT.
  - start=0: stay in IDLE.
- SHIFT (busy=1), at each edge:
  - Bit cell: d = a_sh[0]^b_sh[0]^borrow; bnext = (~a_sh[0]&b_sh[0]) | (~(a_sh[0]^b_sh[0])&borrow).
  - res_sh <= {d, res_sh[WIDTH-1:1]}; a_sh and b_sh shift right by 1; borrow<=bnext; cnt<=cnt+1.
  - On the edge where cnt==WIDTH-1: diff<={d, res_sh[WIDTH-1:1]}, borrow_out<=bnext; go to DONE.
- DONE:
  - done=1, busy=0 for exactly one cycle; next edge always returns to IDLE.
- Timing:
  - done is high in the cycle following the WIDTH-th edge after the accepting edge.
  - Throughput is one operation per WIDTH+2 cycles.
- start while in SHIFT or DONE is ignored and not queued.
- With start held high continuously, a new operation is accepted on the IDLE edge right after done.
- Arithmetic is modulo 2^WIDTH:
  - diff = (a - b) mod 2^WIDTH.
  - borrow_out = (a < b) unsigned.
- Operand changes after the accepting edge have no effect.
- cnt width: $clog2(WIDTH); no wrap beyond WIDTH-1.

Optional Feature:
- Macro: SERIAL_SUBTRACTOR_OVERFLOW_EN.
- Defined:
  - Adds output port overflow (output, 1 bit).
  - Written at the same edge as diff: overflow = (a[MSB] != b[MSB]) && (d_MSB != a[MSB]), i.e. signed two's-complement overflow.
  - Uses an extra flop that captures the sign bits of a and b at the accepting edge.
  - Reset value 0; held until the next result is written.
- Not defined: port and logic are absent; all other behaviour is identical.

Decomposition:
- Package serial_sub_pkg:
  - state enum (IDLE=2'd0, SHIFT=2'd1, DONE=2'd2).
  - Constant DEFAULT_WIDTH=8.
- Sub-module full_subtractor (diff, borrow, a, b, borrow_in):
  - Gate-level, matching the team's gate-primitive adder cells.
  - One instance per serial_subtractor.

Test Plan:
1. WIDTH=8, a=8'h5A, b=8'h3C, start pulse -> busy high 8 cycles; done pulse 8 edges after accept; diff=8'h1E, borrow_out=0.
2. a=8'h00, b=8'h01 -> diff=8'hFF, borrow_out=1; a=b=8'hFF -> diff=8'h00, borrow_out=0.
3. start re-pulsed and a/b changed during SHIFT -> ignored; result still the original a-b; exactly one done pulse.
4. reset asserted at the 4th SHIFT edge -> next cycle busy=0, done=0, diff=0, state IDLE; a following start with a=8'h10, b=8'h01 gives diff=8'h0F.
5. start held high across three operations -> accepts spaced exactly WIDTH+2 cycles apart; each done correct.
6. With SERIAL_SUBTRACTOR_OVERFLOW_EN: a=8'h80, b=8'h01 -> diff=8'h7F, overflow=1; a=8'h05, b=8'h03 -> overflow=0.

Source files
------------

// File: rtl/serial_sub_pkg.sv
// -----------------------------------------------------------------------------
// serial_sub_pkg
// Shared types and constants for the bit-serial subtractor.
//   state_t        : controller states (IDLE, SHIFT, DONE)
//   DEFAULT_WIDTH  : default operand/result width
// -----------------------------------------------------------------------------
package serial_sub_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage : serial_sub_pkg

// File: rtl/serial_subtractor_if.sv
// -----------------------------------------------------------------------------
// serial_subtractor_if
// Handshake and data bundle between a controlling FSM (master) and the
// bit-serial subtractor (slave).
//   start      : request, sampled only while the subtractor is idle
//   a, b       : minuend / subtrahend, captured on the accepting edge
//   diff       : result register, held until the next result
//   borrow_out : final borrow (a < b unsigned)
//   busy       : high while bits are being shifted
//   done       : one-cycle pulse, results valid from this cycle on
//   overflow   : signed overflow flag (only with SERIAL_SUBTRACTOR_OVERFLOW_EN)
// -----------------------------------------------------------------------------
interface serial_subtractor_if #(
    parameter int WIDTH = serial_sub_pkg::DEFAULT_WIDTH
);

    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] diff;
    logic             borrow_out;
    logic             busy;
    logic             done;
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
    logic             overflow;
`endif

    modport master (
        output start, a, b,
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
        input  overflow,
`endif
        input  diff, borrow_out, busy, done
    );

    modport slave (
        input  start, a, b,
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
        output overflow,
`endif
        output diff, borrow_out, busy, done
    );

endinterface : serial_subtractor_if

// File: rtl/full_subtractor.sv
// -----------------------------------------------------------------------------
// full_subtractor
// One-bit full subtractor built from gate primitives, mirror of the adder cells.
//   a, b, borrow_in : minuend bit, subtrahend bit, incoming borrow
//   diff            : a ^ b ^ borrow_in
//   borrow          : (~a & b) | (~(a ^ b) & borrow_in)
// -----------------------------------------------------------------------------
module full_subtractor (
    output logic diff,
    output logic borrow,
    input  logic a,
    input  logic b,
    input  logic borrow_in
);

    logic a_x_b;
    logic a_n;
    logic a_x_b_n;
    logic gen_borrow;
    logic prop_borrow;

    xor g_x1 (a_x_b, a, b);
    xor g_x2 (diff, a_x_b, borrow_in);

    // Borrow is generated when a=0,b=1, and propagated when a==b.
    not g_n1 (a_n, a);
    and g_a1 (gen_borrow, a_n, b);
    not g_n2 (a_x_b_n, a_x_b);
    and g_a2 (prop_borrow, a_x_b_n, borrow_in);
    or  g_o1 (borrow, gen_borrow, prop_borrow);

endmodule : full_subtractor

// File: rtl/serial_subtractor.sv
// -----------------------------------------------------------------------------
// serial_subtractor
// Bit-serial WIDTH-bit subtractor: diff = a - b, LSB first, one bit per clock,
// using a single full_subtractor cell and a borrow flop.
//   clk   : rising-edge clock
//   reset : synchronous, active-high reset
//   bus   : serial_subtractor_if.slave (start/a/b in; diff/borrow_out/busy/done out)
// Optional: define SERIAL_SUBTRACTOR_OVERFLOW_EN to add bus.overflow, the signed
// two's-complement overflow of the subtraction, written together with diff.
// Timing: accept edge, WIDTH shift edges, one DONE cycle, back to IDLE
// (one operation per WIDTH+2 cycles).
// -----------------------------------------------------------------------------
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input logic                clk,
    input logic                reset,
    serial_subtractor_if.slave bus
);

    localparam int CNT_W = $clog2(WIDTH);

    state_t           state_q,      state_d;
    logic [WIDTH-1:0] a_sh_q,       a_sh_d;
    logic [WIDTH-1:0] b_sh_q,       b_sh_d;
    // Holds the WIDTH-1 result bits already produced; the final bit comes
    // straight from the cell on the last edge.
    logic [WIDTH-2:0] res_sh_q,     res_sh_d;
    logic [WIDTH-1:0] diff_q,       diff_d;
    logic             borrow_q,     borrow_d;
    logic             borrow_out_q, borrow_out_d;
    logic [CNT_W-1:0] cnt_q,        cnt_d;
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
    logic [1:0]       sign_q,       sign_d;    // {a[MSB], b[MSB]} of the operation
    logic             overflow_q,   overflow_d;
`endif

    logic             cell_diff;
    logic             cell_borrow;
    logic [WIDTH-1:0] diff_next;
    logic             last_bit;

    full_subtractor u_cell (
        .diff      (cell_diff),
        .borrow    (cell_borrow),
        .a         (a_sh_q[0]),
        .b         (b_sh_q[0]),
        .borrow_in (borrow_q)
    );

    // Result as it stands after this edge's bit is shifted in from the top.
    assign diff_next = {cell_diff, res_sh_q};
    assign last_bit  = (cnt_q == CNT_W'(WIDTH - 1));

    always_comb begin
        // NOTE: every _d gets its hold value first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        state_d      = state_q;
        a_sh_d       = a_sh_q;
        b_sh_d       = b_sh_q;
        res_sh_d     = res_sh_q;
        diff_d       = diff_q;
        borrow_d     = borrow_q;
        borrow_out_d = borrow_out_q;
        cnt_d        = cnt_q;
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
        sign_d       = sign_q;
        overflow_d   = overflow_q;
`endif

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    a_sh_d   = bus.a;
                    b_sh_d   = bus.b;
                    borrow_d = 1'b0;
                    cnt_d    = '0;
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
                    sign_d   = {bus.a[WIDTH-1], bus.b[WIDTH-1]};
`endif
                    state_d  = SHIFT;
                end
            end

            SHIFT: begin
                a_sh_d   = a_sh_q >> 1;
                b_sh_d   = b_sh_q >> 1;
                res_sh_d = diff_next[WIDTH-1:1];
                borrow_d = cell_borrow;
                if (last_bit) begin
                    // Counter holds at WIDTH-1 rather than wrapping.
                    diff_d       = diff_next;
                    borrow_out_d = cell_borrow;
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
                    // Operands of differing sign whose result sign differs
                    // from the minuend's overflowed.
                    overflow_d   = (sign_q[1] != sign_q[0]) && (cell_diff != sign_q[1]);
`endif
                    state_d      = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            DONE:    state_d = IDLE;

            default: state_d = IDLE;
        endcase
    end

    // NOTE: state uses non-blocking assignments so every flop samples the
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: the shift registers are reset too, so an aborted operation
            // leaves no stale bits behind.
            state_q      <= IDLE;
            a_sh_q       <= '0;
            b_sh_q       <= '0;
            res_sh_q     <= '0;
            diff_q       <= '0;
            borrow_q     <= 1'b0;
            borrow_out_q <= 1'b0;
            cnt_q        <= '0;
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
            sign_q       <= 2'b00;
            overflow_q   <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            a_sh_q       <= a_sh_d;
            b_sh_q       <= b_sh_d;
            res_sh_q     <= res_sh_d;
            diff_q       <= diff_d;
            borrow_q     <= borrow_d;
            borrow_out_q <= borrow_out_d;
            cnt_q        <= cnt_d;
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
            sign_q       <= sign_d;
            overflow_q   <= overflow_d;
`endif
        end
    end

    assign bus.diff       = diff_q;
    assign bus.borrow_out = borrow_out_q;
    assign bus.busy       = (state_q == SHIFT);
    assign bus.done       = (state_q == DONE);
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
    assign bus.overflow   = overflow_q;
`endif

endmodule : serial_subtractor
